// File: rtl/ex_8_8_pkg.sv
// Shared sizing and FSM encoding for the ex_8_8 ones-counting design.
package ex_8_8_pkg;
  localparam int r1_size = 8;
  localparam int r2_size = 4;

  localparam logic PWR = 1'b1;
  localparam logic GND = 1'b0;

  typedef enum logic [1:0] {S_IDLE, S_INC, S_TEST, S_CHK} state_t;
endpackage

// File: rtl/ones_count_ctrl.sv
// Control FSM for the ex_8_8 ones counter: sequences load/shift/increment on
// data_path and publishes the final count with a start/ready/done handshake.
module ones_count_ctrl
  import ex_8_8_pkg::*;
(
  input  logic               clk,
  input  logic               rstb,
  input  logic               start,
  input  logic               abort,
  input  logic               zero,
  input  logic               msb,
  input  logic [r2_size-1:0] count,
  output logic               load_regs,
  output logic               shift_left,
  output logic               incr_r2,
  output logic               ready,
  output logic               done,
  output logic [r2_size-1:0] result
);

  state_t state, state_nxt;
  logic   finish;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state  <= S_IDLE;
      done   <= GND;
      result <= '0;
    end else begin
      state <= state_nxt;
      done  <= finish;
      if (finish) result <= count;
    end
  end

  // abort overrides every busy state and suppresses that cycle's control strobes
  always_comb begin
    state_nxt  = state;
    load_regs  = GND;
    shift_left = GND;
    incr_r2    = GND;
    ready      = GND;
    finish     = GND;
    case (state)
      S_IDLE: begin
        ready = PWR;
        if (start && !abort) begin
          load_regs = PWR;
          state_nxt = S_INC;
        end
      end
      S_INC: begin
        if (abort) state_nxt = S_IDLE;
        else begin
          incr_r2   = PWR;
          state_nxt = S_TEST;
        end
      end
      S_TEST: begin
        if (abort) state_nxt = S_IDLE;
        else if (zero) begin
          finish    = PWR;
          state_nxt = S_IDLE;
        end else begin
          shift_left = PWR;
          state_nxt  = S_CHK;
        end
      end
      S_CHK: begin
        if (abort)    state_nxt = S_IDLE;
        else if (msb) state_nxt = S_INC;
        else          state_nxt = S_TEST;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: doc/ones_count_ctrl.md
Name: ones_count_ctrl

Overview:
- Control unit for the ex_8_8 ones-counting datapath (r1 shift register, r2 counter, msb flop).
- Sequences load, shift and increment so that r2 ends holding the number of 1 bits in the loaded word.
- Adds a start/ready/done handshake, a held result register and a synchronous abort.
- Sits beside data_path under the ex_8_8 top level. Drives its control inputs and consumes its zero, msb and count outputs.

Parameters:
- No module-local parameters; all sizing comes from ex_8_8_pkg.
- r1_size, default 8: data word width (package constant).
- r2_size, default 4: count/result width (package constant); must satisfy 2**r2_size > r1_size.

Ports:
- clk  in  1  system clock, rising edge
- rstb  in  1  asynchronous active-low reset
- start  in  1  request a count; sampled only in S_IDLE
- abort  in  1  synchronous cancel; return to S_IDLE with no done
- zero  in  1  from data_path: r1 == 0
- msb  in  1  from data_path: registered bit shifted out of r1 on the previous shift
- count  in  r2_size  from data_path: r2 value
- load_regs  out  1  to data_path: r1 <= data, r2 <= all ones
- shift_left  out  1  to data_path: shift r1 left by one, zero fill
- incr_r2  out  1  to data_path: r2 <= r2 + 1
- ready  out  1  high in S_IDLE
- done  out  1  one-cycle pulse when result is updated
- result  out  r2_size  last completed count, held until the next completion

Behaviour:
- Reset (rstb low, asynchronous): state S_IDLE, done 0, result 0. Control outputs are combinational from state, so all are 0 and ready is 1.
- States (enum in package): S_IDLE, S_INC, S_TEST, S_CHK.
- S_IDLE: ready=1. If start=1 and abort=0: load_regs=1, go to S_INC; otherwise stay.
- S_INC: incr_r2=1, go to S_TEST. The first pass wraps r2 from all ones to 0.
- S_TEST, zero=1: result <= count, done <= 1 at the same edge, go to S_IDLE.
- S_TEST, zero=0: shift_left=1, go to S_CHK.
- S_CHK: no outputs. msb=1 goes to S_INC; msb=0 goes to S_TEST.
- Output exclusivity: load_regs, shift_left and incr_r2 are mutually exclusive. At most one is high per cycle, and none is high outside its listed state.
- done: a registered single-cycle pulse. It is high in the cycle immediately after the S_TEST/zero edge, i.e. the first S_IDLE cycle, when ready is also 1.
- start while busy (not S_IDLE): ignored. It is not queued.
- start held high in S_IDLE on the done cycle: accepted, so a new run begins back-to-back.
- abort=1 in any non-IDLE state: next state S_IDLE, all control outputs 0 that cycle, no done, result unchanged.
- abort and start both high in S_IDLE: abort wins and the FSM stays idle.
- Latency from the start edge to done high = 3 + 2*S + N cycles.
  - N = number of 1 bits in the data word.
  - S = r1_size - (index of lowest set bit); S = 0 for data 0.
- Unreachable state encodings: return to S_IDLE.
- Reset asserted mid-run: immediate return to the reset values; the data_path registers reset independently.

Decomposition:
- ex_8_8_pkg holds: r1_size, r2_size, PWR, GND, and typedef enum logic [1:0] state_t {S_IDLE, S_INC, S_TEST, S_CHK}.
- ones_count_ctrl is flat: one always_ff for state/result/done, one always_comb for next state and outputs.
- No sub-module. Integration with data_path happens in the ex_8_8 top level, outside this block.

Test Plan:
- Reset: rstb low mid-run with data=8'hFF -> ready=1, done=0, result=0 asynchronously; all control outputs 0.
- data=8'h00, start pulse -> load_regs, incr_r2, then done 3 cycles after the start edge; result=0; shift_left never asserted.
- data=8'h80 -> done 6 cycles after start, result=1. data=8'h01 -> done 20 cycles after start, result=1.
- data=8'hFF -> done 27 cycles after start, result=8. data=8'hA5 -> result=4, done at 3+16+4=23 cycles.
- start held high throughout a run -> no restart mid-run; a second run starts on the done cycle; result updates per run.
- abort in S_CHK during data=8'hFF -> S_IDLE next cycle, no done, result keeps its previous value. Abort with start in S_IDLE -> stays idle.
